// File: rtl/alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_unit                                                 |
// | Description : Multi-cycle ALU. Decodes alu_op/funct into alu_ctl,          |
// |               executes single-cycle ops (add/sub/and/or/slt/mfhi/mflo)     |
// |               and iterative unsigned multiply/divide into HI/LO, and       |
// |               returns a registered result over a valid/ready handshake.    |
// | Ports       : clk, rst (async, active-high)                                |
// |               in_valid/in_ready, alu_op[1:0], funct[5:0], a, b  (request)  |
// |               out_valid/out_ready, result, zero, alu_ctl[3:0], illegal     |
// | Config      : ALU_DIV_EN - when defined, divu (funct 011011) is decoded    |
// |               and executed; otherwise it is reported as illegal.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       alu_ctl,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_SLT   = 4'b0111;
    localparam logic [3:0] CTL_MULTU = 4'b1000;
    localparam logic [3:0] CTL_DIVU  = 4'b1001;
    localparam logic [3:0] CTL_MFHI  = 4'b1010;
    localparam logic [3:0] CTL_MFLO  = 4'b1011;
    localparam logic [3:0] CTL_ILL   = 4'b1111;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             zero_q,    zero_d;
    logic [3:0]       alu_ctl_q, alu_ctl_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    // Iteration working set: wk_hi = partial product / remainder,
    // wk_lo = multiplier / dividend-shifting-into-quotient,
    // opnd = multiplicand / divisor.
    logic [WIDTH-1:0] wk_hi_q,   wk_hi_d;
    logic [WIDTH-1:0] wk_lo_q,   wk_lo_d;
    logic [WIDTH-1:0] opnd_q,    opnd_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic [3:0]       w_ctl;
    logic             w_illegal;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
    logic [WIDTH-1:0] w_div_hi, w_div_lo;
    logic             w_last;

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_ctl     = CTL_ILL;
        w_illegal = 1'b1;
        case (alu_op)
            2'b00: begin w_ctl = CTL_ADD; w_illegal = 1'b0; end
            2'b01: begin w_ctl = CTL_SUB; w_illegal = 1'b0; end
            2'b11: begin w_ctl = CTL_OR;  w_illegal = 1'b0; end
            default: begin
                case (funct)
                    6'b100000: begin w_ctl = CTL_ADD;   w_illegal = 1'b0; end
                    6'b100010: begin w_ctl = CTL_SUB;   w_illegal = 1'b0; end
                    6'b100100: begin w_ctl = CTL_AND;   w_illegal = 1'b0; end
                    6'b100101: begin w_ctl = CTL_OR;    w_illegal = 1'b0; end
                    6'b101010: begin w_ctl = CTL_SLT;   w_illegal = 1'b0; end
                    6'b011001: begin w_ctl = CTL_MULTU; w_illegal = 1'b0; end
`ifdef ALU_DIV_EN
                    6'b011011: begin w_ctl = CTL_DIVU;  w_illegal = 1'b0; end
`endif
                    6'b010000: begin w_ctl = CTL_MFHI;  w_illegal = 1'b0; end
                    6'b010010: begin w_ctl = CTL_MFLO;  w_illegal = 1'b0; end
                    default:   begin w_ctl = CTL_ILL;   w_illegal = 1'b1; end
                endcase
            end
        endcase
    end

    // ----------------------------------------------------- single-cycle ops
    always_comb begin
        w_alu_res = '0;
        case (w_ctl)
            CTL_ADD:  w_alu_res = a + b;
            CTL_SUB:  w_alu_res = a - b;
            CTL_AND:  w_alu_res = a & b;
            CTL_OR:   w_alu_res = a | b;
            CTL_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTL_MFHI: w_alu_res = hi_q;
            CTL_MFLO: w_alu_res = lo_q;
            default:  w_alu_res = '0;
        endcase
    end

    // ------------------------------------------- shift-add multiply step
    // Add multiplicand when the current multiplier LSB is set, then shift the
    // {carry, hi, lo} chain right; after WIDTH steps {hi, lo} is the product.
    assign w_mul_sum = {1'b0, wk_hi_q} + (wk_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], wk_lo_q[WIDTH-1:1]};

    // ------------------------------------------- restoring divide step
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;

    // A zero divisor always compares "greater or equal", so every quotient
    // bit becomes 1 and the remainder ends as the dividend: LO=~0, HI=a.
    assign w_div_shift = {wk_hi_q, wk_lo_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
    // Difference is < divisor whenever it is used, so WIDTH bits suffice.
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - opnd_q;
    assign w_div_hi    = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {wk_lo_q[WIDTH-2:0], w_div_ge};
`else
    assign w_div_hi = wk_hi_q;
    assign w_div_lo = wk_lo_q;
`endif

    assign w_last = (count_q == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        alu_ctl_d = alu_ctl_q;
        illegal_d = illegal_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        wk_hi_d   = wk_hi_q;
        wk_lo_d   = wk_lo_q;
        opnd_d    = opnd_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    count_d = '0;
                    wk_hi_d = '0;
                    if (w_ctl == CTL_MULTU) begin
                        state_d = ST_MUL;
                        wk_lo_d = b;
                        opnd_d  = a;
                    end else if (w_ctl == CTL_DIVU) begin
                        state_d = ST_DIV;
                        wk_lo_d = a;
                        opnd_d  = b;
                    end else begin
                        state_d   = ST_DONE;
                        result_d  = w_alu_res;
                        zero_d    = (w_alu_res == '0);
                        alu_ctl_d = w_ctl;
                        illegal_d = w_illegal;
                    end
                end
            end
            ST_MUL: begin
                wk_hi_d = w_mul_hi;
                wk_lo_d = w_mul_lo;
                count_d = count_q + CNT_W'(1);
                if (w_last) begin
                    state_d   = ST_DONE;
                    hi_d      = w_mul_hi;
                    lo_d      = w_mul_lo;
                    result_d  = w_mul_lo;
                    zero_d    = (w_mul_lo == '0);
                    alu_ctl_d = CTL_MULTU;
                    illegal_d = 1'b0;
                end
            end
            ST_DIV: begin
                wk_hi_d = w_div_hi;
                wk_lo_d = w_div_lo;
                count_d = count_q + CNT_W'(1);
                if (w_last) begin
                    state_d   = ST_DONE;
                    hi_d      = w_div_hi;
                    lo_d      = w_div_lo;
                    result_d  = w_div_lo;
                    zero_d    = (w_div_lo == '0);
                    alu_ctl_d = CTL_DIVU;
                    illegal_d = 1'b0;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            alu_ctl_q <= CTL_AND;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            wk_hi_q   <= '0;
            wk_lo_q   <= '0;
            opnd_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            alu_ctl_q <= alu_ctl_d;
            illegal_q <= illegal_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            wk_hi_q   <= wk_hi_d;
            wk_lo_q   <= wk_lo_d;
            opnd_q    <= opnd_d;
            count_q   <= count_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign alu_ctl   = alu_ctl_q;
    assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_seq_unit                                              |
// | Description : Self-checking bench for alu_seq_unit (WIDTH=32) using a      |
// |               behavioural reference model of the ALU and HI/LO state.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic [3:0]   alu_ctl;
    logic         illegal;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .alu_ctl  (alu_ctl),
        .illegal  (illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference HI/LO as seen by the programmer.
    logic [W-1:0] m_hi, m_lo;

    // Observed response of the last operation.
    logic [W-1:0] o_res;
    logic [3:0]   o_ctl;
    logic         o_ill, o_zero;
    int           o_lat;

    // Expected response of the last operation.
    logic [W-1:0] e_res;
    logic [3:0]   e_ctl;
    logic         e_ill;
    int           e_lat;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   f;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } req_t;

    // Architectural behaviour: what a MIPS-like ALU would return.
    task automatic model_op(input logic [1:0] op, input logic [5:0] f,
                            input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        e_ill = 1'b0;
        e_lat = 1;
        e_res = '0;
        e_ctl = 4'b1111;
        case (op)
            2'b00: begin e_ctl = 4'b0010; e_res = x + y; end
            2'b01: begin e_ctl = 4'b0110; e_res = x - y; end
            2'b11: begin e_ctl = 4'b0001; e_res = x | y; end
            default: begin
                case (f)
                    6'h20: begin e_ctl = 4'b0010; e_res = x + y; end
                    6'h22: begin e_ctl = 4'b0110; e_res = x - y; end
                    6'h24: begin e_ctl = 4'b0000; e_res = x & y; end
                    6'h25: begin e_ctl = 4'b0001; e_res = x | y; end
                    6'h2A: begin e_ctl = 4'b0111; e_res = ($signed(x) < $signed(y)) ? 1 : 0; end
                    6'h19: begin
                        prod  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                        m_hi  = prod[2*W-1:W];
                        m_lo  = prod[W-1:0];
                        e_ctl = 4'b1000; e_res = m_lo; e_lat = W + 1;
                    end
`ifdef ALU_DIV_EN
                    6'h1B: begin
                        if (y == 0) begin m_lo = '1; m_hi = x; end
                        else begin m_lo = x / y; m_hi = x % y; end
                        e_ctl = 4'b1001; e_res = m_lo; e_lat = W + 1;
                    end
`endif
                    6'h10: begin e_ctl = 4'b1010; e_res = m_hi; end
                    6'h12: begin e_ctl = 4'b1011; e_res = m_lo; end
                    default: begin e_ctl = 4'b1111; e_res = '0; e_ill = 1'b1; end
                endcase
            end
        endcase
    endtask

    // Issue one request from IDLE and wait (bounded) for its response.
    // With poke set, a bogus request is held on the input while busy.
    task automatic exec_op(input logic [1:0] op, input logic [5:0] f,
                           input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        @(negedge clk);
        alu_op = op; funct = f; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = poke;
        if (poke) begin alu_op = 2'b00; a = $urandom; b = $urandom; end
        o_lat = 1;
        while (out_valid !== 1'b1 && o_lat < 100) begin
            @(posedge clk);
            #1;
            o_lat++;
        end
        in_valid = 1'b0;
        if (out_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, required 1", out_valid, o_lat);
        end
        o_res = result; o_ctl = alu_ctl; o_ill = illegal; o_zero = zero;
    endtask

    task automatic release_out(input int delay);
        repeat (delay) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; funct = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h, required 0", result); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b, required 1", zero); end
        n_checks++; if (alu_ctl !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_ctl: got %b, required 0000", alu_ctl); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b, required 0", illegal); end
    endtask

    task automatic test_directed();
        req_t tbl[$];
        tbl.push_back('{2'b10, 6'h20, 32'd5, 32'd7});
        tbl.push_back('{2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1});
        tbl.push_back('{2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF});
        tbl.push_back('{2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2});
        tbl.push_back('{2'b10, 6'h10, 32'd0, 32'd0});
        tbl.push_back('{2'b10, 6'h1B, 32'd100, 32'd7});
        tbl.push_back('{2'b10, 6'h10, 32'd0, 32'd0});
        tbl.push_back('{2'b10, 6'h1B, 32'd1234, 32'd0});
        tbl.push_back('{2'b10, 6'h10, 32'd0, 32'd0});
        tbl.push_back('{2'b10, 6'h12, 32'd0, 32'd0});
        tbl.push_back('{2'b10, 6'h3F, 32'd9, 32'd9});
        tbl.push_back('{2'b10, 6'h22, 32'd3, 32'd5});
        tbl.push_back('{2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF});
        tbl.push_back('{2'b10, 6'h25, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{2'b00, 6'h3F, 32'hFFFF_FFFF, 32'd1});
        tbl.push_back('{2'b01, 6'h00, 32'd10, 32'd10});
        tbl.push_back('{2'b11, 6'h00, 32'h1200_0000, 32'h0000_0034});
        foreach (tbl[i]) begin
            model_op(tbl[i].op, tbl[i].f, tbl[i].x, tbl[i].y);
            exec_op(tbl[i].op, tbl[i].f, tbl[i].x, tbl[i].y, 1'b0);
            n_checks++; if (o_res !== e_res) begin n_fail++; $display("FAIL dir%0d_result: got %h, required %h", i, o_res, e_res); end
            n_checks++; if (o_ctl !== e_ctl) begin n_fail++; $display("FAIL dir%0d_alu_ctl: got %b, required %b", i, o_ctl, e_ctl); end
            n_checks++; if (o_ill !== e_ill) begin n_fail++; $display("FAIL dir%0d_illegal: got %b, required %b", i, o_ill, e_ill); end
            n_checks++; if (o_zero !== (e_res == 0)) begin n_fail++; $display("FAIL dir%0d_zero: got %b, required %b", i, o_zero, (e_res == 0)); end
            n_checks++; if (o_lat != e_lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d, required %0d", i, o_lat, e_lat); end
            release_out(0);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] x, y;
        x = $urandom; y = $urandom;
        model_op(2'b10, 6'h20, x, y);
        exec_op(2'b10, 6'h20, x, y, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_op = 2'b11; a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold%0d_out_valid: got %b, required 1", c, out_valid); end
            n_checks++; if (result !== e_res) begin n_fail++; $display("FAIL hold%0d_result: got %h, required %h", c, result, e_res); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_in_ready: got %b, required 0", c, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out(0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_in_ready: got %b, required 1", in_ready); end
        // A request presented while a multiply runs must be dropped.
        x = $urandom; y = $urandom;
        model_op(2'b10, 6'h19, x, y);
        exec_op(2'b10, 6'h19, x, y, 1'b1);
        n_checks++; if (o_res !== e_res) begin n_fail++; $display("FAIL busy_multu_result: got %h, required %h", o_res, e_res); end
        n_checks++; if (o_ctl !== e_ctl) begin n_fail++; $display("FAIL busy_multu_alu_ctl: got %b, required %b", o_ctl, e_ctl); end
        release_out(0);
        model_op(2'b10, 6'h10, 0, 0);
        exec_op(2'b10, 6'h10, 0, 0, 1'b0);
        n_checks++; if (o_res !== e_res) begin n_fail++; $display("FAIL busy_mfhi_result: got %h, required %h", o_res, e_res); end
        release_out(0);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x, y;
        x = 32'hDEAD_BEEF; y = 32'h1234_5678;
        @(negedge clk);
        alu_op = 2'b10; funct = 6'h19; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL midrst_result: got %h, required 0", result); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL midrst_zero: got %b, required 1", zero); end
        @(negedge clk);
        rst = 1'b0;
        model_op(2'b10, 6'h10, 0, 0);
        exec_op(2'b10, 6'h10, 0, 0, 1'b0);
        n_checks++; if (o_res !== e_res) begin n_fail++; $display("FAIL midrst_hi: got %h, required %h", o_res, e_res); end
        release_out(0);
        model_op(2'b10, 6'h12, 0, 0);
        exec_op(2'b10, 6'h12, 0, 0, 1'b0);
        n_checks++; if (o_res !== e_res) begin n_fail++; $display("FAIL midrst_lo: got %h, required %h", o_res, e_res); end
        release_out(0);
    endtask

    task automatic test_random();
        logic [5:0]   codes [10];
        logic [1:0]   op;
        logic [5:0]   f;
        logic [W-1:0] x, y;
        int           k;
        codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h19, 6'h1B, 6'h10, 6'h12, 6'h3F};
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) op = 2'b10;
            k = $urandom_range(0, 10);
            f = (k == 10) ? 6'($urandom) : codes[k];
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            model_op(op, f, x, y);
            exec_op(op, f, x, y, 1'b0);
            n_checks++; if (o_res !== e_res) begin n_fail++; $display("FAIL rnd%0d_result op=%b f=%h a=%h b=%h: got %h, required %h", i, op, f, x, y, o_res, e_res); end
            n_checks++; if (o_ctl !== e_ctl) begin n_fail++; $display("FAIL rnd%0d_alu_ctl: got %b, required %b", i, o_ctl, e_ctl); end
            n_checks++; if (o_ill !== e_ill) begin n_fail++; $display("FAIL rnd%0d_illegal: got %b, required %b", i, o_ill, e_ill); end
            n_checks++; if (o_zero !== (e_res == 0)) begin n_fail++; $display("FAIL rnd%0d_zero: got %b, required %b", i, o_zero, (e_res == 0)); end
            n_checks++; if (o_lat != e_lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d, required %0d", i, o_lat, e_lat); end
            release_out($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
